mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Drives the 2-bit select of the 4:1 mux (`mux4_to_1`) and samples its single-bit output once per channel.
- Scans channels 0..NUM_CH-1 in order and holds each select value for DWELL cycles so the mux path can settle.
- Packs the sampled bits into one frame word and offers it downstream on a valid/ready handshake.
- Sits between the control logic that requests scans and the consumer of the multiplexed channel data.

Parameters:
- NUM_CH, 4: channels scanned per frame; range 2..2**SEL_W.
- SEL_W, 2: select width. Bit 1 maps to S1, bit 0 maps to S0.
- DWELL, 2: cycles each select value is held before its sample is taken; must be ≥1.
- CNT_W, 8: dwell counter width; requires DWELL ≤ 2**CNT_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request one scan; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at frame handshake.
- mux_out  in  1  mux OUTPUT.
- sel  out  SEL_W  mux select {S1,S0}.
- frame  out  NUM_CH  captured bits; bit i = value of channel i.
- frame_valid  out  1  frame is available.
- frame_ready  in  1  consumer accepts the frame.
- busy  out  1  high in SETTLE or HOLD.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - State IDLE; sel=0, frame=0, shadow=0, frame_valid=0, busy=0, dwell_cnt=0.
  - Reset mid-scan aborts immediately. No partial frame is ever presented.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - sel=0, busy=0.
  - start=1 at edge E0 → SETTLE with ch=0, dwell_cnt=0.
- SETTLE:
  - sel=ch. dwell_cnt increments every cycle.
  - On the edge where dwell_cnt==DWELL-1: shadow[ch] ← mux_out and dwell_cnt ← 0.
    - If ch<NUM_CH-1: ch++ and stay in SETTLE.
    - Else: frame ← shadow with bit ch replaced by mux_out, frame_valid ← 1, go to HOLD.
  - Channel i is sampled at edge E0+(i+1)·DWELL. frame_valid rises after edge E0+NUM_CH·DWELL (8 cycles at defaults).
- HOLD:
  - sel holds NUM_CH-1. frame and frame_valid are stable until the handshake.
  - Handshake = frame_valid && frame_ready at a rising edge.
    - cont=1: → SETTLE, ch=0, frame_valid=0 next cycle.
    - cont=0: → IDLE, frame_valid=0.
  - frame_ready while frame_valid=0 has no effect.
- start is ignored while busy. start and handshake in the same cycle in HOLD: the handshake rule applies and start is ignored.
- frame keeps the last captured value after the handshake until the next frame completes.
- ch wraps only via reset to 0. It never exceeds NUM_CH-1, even when NUM_CH < 2**SEL_W.
- All outputs are registered. No combinational path from input to output.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: adds output frame_par (1 bit).
  - Registered with frame, equal to XOR of the new frame bits.
  - Reset value 0. Valid whenever frame_valid=1.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - state enum (IDLE, SETTLE, HOLD).
  - Default constants NUM_CH_D=4, SEL_W_D=2, DWELL_D=2.
- Sub-module mux_scan_dwell_cnt:
  - Parameterised CNT_W/DWELL counter with clear input and a terminal pulse at DWELL-1.
  - Resets asynchronously on rst_n.

Test Plan:
1. Single scan, defaults. IN0=1, IN1=0, IN2=1, IN3=0; start pulse at E0, cont=0, frame_ready=1.
   → sel goes 0,0,1,1,2,2,3,3. frame=4'b0101 with frame_valid high after edge E0+8. Returns to IDLE next cycle and busy drops.
2. Back-pressure. Same inputs, frame_ready=0 for 10 cycles after valid, then 1.
   → frame_valid stays 1, frame stays 4'b0101, sel stays 3. Clears one cycle after ready.
3. Continuous mode. cont=1, frame_ready=1; change IN0..IN3 to 0,1,1,0 during the second scan before each channel's sample edge.
   → First frame 4'b0101, second frame 4'b0110. Consecutive frame_valid pulses are 9 cycles apart.
4. Reset mid-operation. rst_n low at E0+5 for 1 cycle.
   → Outputs immediately sel=0, frame=0, frame_valid=0, busy=0. A subsequent start yields a clean 4'b0101.
5. Ignored start. start held high during the whole scan with cont=0.
   → Exactly one frame per IDLE entry. A new scan begins only when start is seen in IDLE.
6. With MUX_SCAN_PARITY_EN, DWELL=1.
   → frame=4'b0101 gives frame_par=0. Inputs 1,1,1,0 give frame_par=1. Valid after E0+4.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and default constants for the mux scan controller.
package mux_scan_pkg;

    // Controller states: waiting for a request, stepping through channels, offering a frame.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StHold   = 2'd2
    } state_e;

    localparam int unsigned NUM_CH_D = 4;
    localparam int unsigned SEL_W_D  = 2;
    localparam int unsigned DWELL_D  = 2;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter: counts cycles while enabled and pulses tc on the DWELL-1 count,
// wrapping back to zero on that same edge. clr forces the count to zero.
module mux_scan_dwell_cnt #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CNT_W-1:0] TcVal = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] dwell_cnt;

    // Terminal pulse is decoded from the registered count, so it lines up with the sample edge.
    always_comb begin
        tc = en && (dwell_cnt == TcVal);
    end

    // Count while enabled, wrap at the terminal value, hold at zero when cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (clr) begin
            dwell_cnt <= '0;
        end else if (en) begin
            if (tc) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan controller: steps the 4:1 mux select through channels 0..NUM_CH-1, holds each
// select for DWELL cycles, samples mux_out at the end of each dwell and offers the packed
// frame on a valid/ready handshake. Optional frame parity output under MUX_SCAN_PARITY_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_D,
    parameter int unsigned SEL_W  = SEL_W_D,
    parameter int unsigned DWELL  = DWELL_D,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] frame,
    output logic              frame_valid,
    input  logic              frame_ready,
`ifdef MUX_SCAN_PARITY_EN
    output logic              frame_par,
`endif
    output logic              busy
);

    localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);

    state_e             state;
    logic [SEL_W-1:0]   ch;
    logic [NUM_CH-1:0]  shadow;
    logic [NUM_CH-1:0]  samp_vec;
    logic               dwell_tc;

    // Counter only runs while settling; it sits at zero in every other state.
    mux_scan_dwell_cnt #(
        .CNT_W (CNT_W),
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == StSettle),
        .clr   (state != StSettle),
        .tc    (dwell_tc)
    );

    // Shadow with the current channel's bit replaced by the live mux output.
    always_comb begin
        samp_vec = shadow;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == SEL_W'(i)) begin
                samp_vec[i] = mux_out;
            end
        end
    end

    // Scan FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            ch          <= '0;
            sel         <= '0;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            frame_par   <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StSettle;
                        ch    <= '0;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                StSettle: begin
                    if (dwell_tc) begin
                        shadow <= samp_vec;
                        if (ch == LastCh) begin
                            // Last channel: publish the complete frame, select stays on it.
                            frame       <= samp_vec;
                            frame_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            frame_par   <= ^samp_vec;
`endif
                            state       <= StHold;
                        end else begin
                            ch  <= ch + 1'b1;
                            sel <= ch + 1'b1;
                        end
                    end
                end
                StHold: begin
                    // Handshake wins over start; cont decides whether to rescan at once.
                    if (frame_valid && frame_ready) begin
                        frame_valid <= 1'b0;
                        ch          <= '0;
                        sel         <= '0;
                        if (cont) begin
                            state <= StSettle;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= StIdle;
                    ch          <= '0;
                    sel         <= '0;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
